// File: rtl/sig_monitor.sv
// Signature monitor: snoops data-memory stores and checks them against per-channel expected values.
// Latency: done/pass/fail/timeout are registered and assert one cycle after the deciding store or count.
// Backpressure: none; the store stream is observed every cycle and never stalled.
module sig_monitor #(
  parameter int N       = 64,
  parameter int NUM_SIG = 4,
  parameter int CW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        max_cycles,
  input  logic [NUM_SIG*N-1:0] sig_addr,
  input  logic [NUM_SIG*N-1:0] sig_expected,
  input  logic                 store_valid,
  input  logic [N-1:0]         store_addr,
  input  logic [N-1:0]         store_data,
  input  logic                 store_word,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [NUM_SIG-1:0]   hit_mask,
  output logic [3:0]           fail_index,
  output logic [CW-1:0]        cycle_count
);

  // Byte-offset bits inside one N-bit word; these never take part in address matching.
  localparam int OFS = (N == 64) ? 3 : 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [NUM_SIG*N-1:0] addr_q;
  logic [NUM_SIG*N-1:0] exp_q;
  logic [CW-1:0]        max_q;

  logic [NUM_SIG-1:0]   addr_hit;
  logic [NUM_SIG-1:0]   data_ok;
  logic [NUM_SIG-1:0]   bad;
  logic [NUM_SIG-1:0]   hit_nxt;
  logic [3:0]           bad_idx;
  logic                 all_hit;
  logic                 last_cycle;
  logic                 restart;
  logic                 done_d;
  logic                 pass_d;
  logic                 fail_d;
  logic                 timeout_d;
  logic                 unused_bits;

  // Per-channel address/data comparison of the current store against the latched configuration.
  always_comb begin
    addr_hit = '0;
    data_ok  = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      addr_hit[i] = store_valid && (store_addr[N-1:OFS] == addr_q[i*N+OFS +: N-OFS]);
      data_ok[i]  = store_word ? (store_data[31:0] == exp_q[i*N +: 32])
                               : (store_data == exp_q[i*N +: N]);
    end
  end

  assign bad        = addr_hit & ~data_ok;
  assign hit_nxt    = hit_mask | (addr_hit & data_ok);
  assign all_hit    = &hit_nxt;
  assign last_cycle = (max_q != '0) && (cycle_count == max_q - CW'(1));
  assign restart    = start && (state_q != S_RUN);

  // Lowest mismatching channel wins when one store lands on several channels.
  always_comb begin
    bad_idx = 4'd0;
    for (int i = NUM_SIG - 1; i >= 0; i--) begin
      if (bad[i]) bad_idx = 4'(i);
    end
  end

  // Byte-offset address bits are deliberately ignored; fold them away explicitly.
  always_comb begin
    unused_bits = ^store_addr[OFS-1:0];
    for (int i = 0; i < NUM_SIG; i++) begin
      unused_bits = unused_bits ^ (^addr_q[i*N +: OFS]);
    end
  end

  // State register together with the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      pass    <= pass_d;
      fail    <= fail_d;
      timeout <= timeout_d;
    end
  end

  // Next-state: mismatch beats completion, completion beats timeout; terminal states wait for start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (|bad)            state_d = S_FAIL;
        else if (all_hit)    state_d = S_PASS;
        else if (last_cycle) state_d = S_TIMEOUT;
      end
      S_PASS, S_FAIL, S_TIMEOUT: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags decoded from the upcoming state so they are registered with it.
  always_comb begin
    pass_d    = (state_d == S_PASS);
    fail_d    = (state_d == S_FAIL);
    timeout_d = (state_d == S_TIMEOUT);
    done_d    = pass_d | fail_d | timeout_d;
  end

  // Configuration latch, hit tracking, fail index and the saturating run-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      exp_q       <= '0;
      max_q       <= '0;
      hit_mask    <= '0;
      fail_index  <= 4'd0;
      cycle_count <= '0;
    end else if (restart) begin
      addr_q      <= sig_addr;
      exp_q       <= sig_expected;
      max_q       <= max_cycles;
      hit_mask    <= '0;
      fail_index  <= 4'd0;
      cycle_count <= '0;
    end else if (state_q == S_RUN) begin
      hit_mask    <= hit_nxt;
      cycle_count <= (&cycle_count) ? cycle_count : cycle_count + CW'(1);
      if (|bad) fail_index <= bad_idx;
    end
  end

endmodule

// File: tb/tb_sig_monitor.sv
// Testbench for sig_monitor: randomized and directed store streams scored against a cycle-walk model.
// Latency: expected terminal result is queued per run and compared whenever done is high.
// Backpressure: none; the bench drives one store per cycle.
module tb_sig_monitor;
  localparam int N    = 64;
  localparam int NS   = 4;
  localparam int CW   = 32;
  localparam int MAXK = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   max_cycles;
  logic [NS*N-1:0] sig_addr;
  logic [NS*N-1:0] sig_expected;
  logic            store_valid;
  logic [N-1:0]    store_addr;
  logic [N-1:0]    store_data;
  logic            store_word;
  logic            done;
  logic            pass;
  logic            fail;
  logic            timeout;
  logic [NS-1:0]   hit_mask;
  logic [3:0]      fail_index;
  logic [CW-1:0]   cycle_count;

  always #5 clk = ~clk;

  sig_monitor #(.N(N), .NUM_SIG(NS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .max_cycles(max_cycles),
    .sig_addr(sig_addr), .sig_expected(sig_expected),
    .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
    .store_word(store_word), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .hit_mask(hit_mask), .fail_index(fail_index), .cycle_count(cycle_count)
  );

  typedef struct packed {
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [NS-1:0] hit;
    logic [3:0]    fidx;
    logic [CW-1:0] cnt;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Run configuration and per-RUN-cycle store schedule
  logic [N-1:0]  c_addr[NS];
  logic [N-1:0]  c_exp[NS];
  logic [CW-1:0] c_max;
  logic          s_vld[MAXK];
  logic          s_word[MAXK];
  logic [N-1:0]  s_addr[MAXK];
  logic [N-1:0]  s_data[MAXK];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Walk the schedule one RUN cycle at a time and decide how the run ends.
  function automatic res_t model(output int len);
    res_t          r;
    logic [NS-1:0] hits;
    int            bad;
    logic          ok;
    r    = '0;
    hits = '0;
    len  = 0;
    for (int k = 0; k < MAXK; k++) begin
      bad = -1;
      if (s_vld[k]) begin
        for (int i = 0; i < NS; i++) begin
          if ((s_addr[k] >> 3) == (c_addr[i] >> 3)) begin
            ok = s_word[k] ? (s_data[k][31:0] == c_exp[i][31:0]) : (s_data[k] == c_exp[i]);
            if (ok) hits[i] = 1'b1;
            else if (bad < 0) bad = i;
          end
        end
      end
      r.hit = hits;
      r.cnt = CW'(k + 1);
      if (bad >= 0) begin
        r.fail = 1'b1; r.fidx = 4'(bad); len = k + 1; return r;
      end
      if (&hits) begin
        r.pass = 1'b1; len = k + 1; return r;
      end
      if (c_max != '0 && k == int'(c_max) - 1) begin
        r.timeout = 1'b1; len = k + 1; return r;
      end
    end
    return r;
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < MAXK; k++) begin
      s_vld[k] = 1'b0; s_word[k] = 1'b0; s_addr[k] = '0; s_data[k] = '0;
    end
  endtask

  task automatic set_st(input int k, input logic [N-1:0] a, input logic [N-1:0] d, input logic w);
    s_vld[k] = 1'b1; s_addr[k] = a; s_data[k] = d; s_word[k] = w;
  endtask

  task automatic set_cfg(input logic [N-1:0] base, input logic [CW-1:0] mx);
    for (int i = 0; i < NS; i++) begin
      c_addr[i] = base + N'(i * 8);
      c_exp[i]  = {$urandom, $urandom};
    end
    c_max = mx;
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < NS; i++) begin
      sig_addr[i*N +: N]     = c_addr[i];
      sig_expected[i*N +: N] = c_exp[i];
    end
    max_cycles = c_max;
  endtask

  task automatic scramble_cfg();
    for (int i = 0; i < NS; i++) begin
      sig_addr[i*N +: N]     = {$urandom, $urandom};
      sig_expected[i*N +: N] = {$urandom, $urandom};
    end
    max_cycles = $urandom;
  endtask

  // Queue the model's verdict, then issue start, the schedule and some ignored trailing stores.
  task automatic run_test(input int extra, input bit chaos);
    res_t r;
    int   len;
    int   ch;
    r = model(len);
    sb_q.push_back(r);
    @(posedge clk); #1;
    drive_cfg();
    start = 1'b1;
    store_valid = 1'b1; store_addr = c_addr[0]; store_data = ~c_exp[0]; store_word = 1'b0;
    for (int k = 0; k < len + extra; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (chaos) begin
        scramble_cfg();
        if (k < len && ($urandom % 16) == 0) start = 1'b1;
      end
      if (k < len) begin
        store_valid = s_vld[k]; store_addr = s_addr[k]; store_data = s_data[k]; store_word = s_word[k];
      end else begin
        ch = $urandom_range(NS - 1, 0);
        store_valid = ($urandom % 2) == 0;
        store_addr  = c_addr[ch]; store_data = ~c_exp[ch]; store_word = 1'b0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; store_valid = 1'b0;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic gen_random();
    logic [N-1:0] base;
    logic [N-1:0] d;
    bit           wrong_mode;
    int           ch;
    base = {$urandom, $urandom} & ~64'h3F;
    for (int i = 0; i < NS; i++) begin
      c_addr[i] = base + N'(i * 8) + N'($urandom % 8);
      c_exp[i]  = {$urandom, $urandom};
    end
    c_max = CW'($urandom_range(100, 1));
    wrong_mode = ($urandom % 3) == 0;
    clear_sched();
    for (int k = 0; k < MAXK; k++) begin
      if (($urandom % 3) == 0) begin
        if (($urandom % 2) == 0) begin
          ch = $urandom_range(NS - 1, 0);
          s_word[k] = ($urandom % 2) == 0;
          d = s_word[k] ? {$urandom, c_exp[ch][31:0]} : c_exp[ch];
          if (wrong_mode && ($urandom % 8) == 0) d = d ^ (64'd1 << ($urandom % 32));
          set_st(k, (c_addr[ch] & ~64'h7) | N'($urandom % 8), d, s_word[k]);
        end else begin
          set_st(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end
      end
    end
  endtask

  // Monitor: pop the expected verdict when done rises and keep comparing while it is held.
  initial begin
    res_t cur;
    bit   have;
    logic prev;
    have = 1'b0;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (!prev) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
            have = 1'b0;
          end else begin
            cur  = sb_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          check("pass", 64'(pass), 64'(cur.pass));
          check("fail", 64'(fail), 64'(cur.fail));
          check("timeout", 64'(timeout), 64'(cur.timeout));
          check("hit_mask", 64'(hit_mask), 64'(cur.hit));
          check("fail_index", 64'(fail_index), 64'(cur.fidx));
          check("cycle_count", 64'(cycle_count), 64'(cur.cnt));
        end
      end else begin
        have = 1'b0;
      end
      prev = done;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_fail"}, 64'(fail), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_hit_mask"}, 64'(hit_mask), 64'd0);
    check({tag, "_fail_index"}, 64'(fail_index), 64'd0);
    check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // Stimulus: reset behaviour, directed corner cases, randomized runs, mid-run abort.
  initial begin
    rst = 1'b1; start = 1'b0; max_cycles = '0; sig_addr = '0; sig_expected = '0;
    store_valid = 1'b0; store_addr = '0; store_data = '0; store_word = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");

    // rst dominates a simultaneous start
    @(posedge clk); #1; start = 1'b1; max_cycles = 32'd5;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_over_start_count", 64'(cycle_count), 64'd0);
    check("rst_over_start_done", 64'(done), 64'd0);

    // single store at offset 0x4 hits every channel (all share word 0) in RUN cycle index 9
    clear_sched();
    for (int i = 0; i < NS; i++) begin c_addr[i] = '0; c_exp[i] = 64'hC0FFEE; end
    c_max = '0;
    set_st(9, 64'h4, 64'hC0FFEE, 1'b0);
    run_test(3, 1'b0);

    // correct store to 0x8 then wrong store to 0x0
    clear_sched();
    set_cfg(64'h0, '0);
    set_st(2, 64'h8, c_exp[1], 1'b0);
    set_st(5, 64'h0, c_exp[0] ^ 64'h1, 1'b0);
    run_test(4, 1'b0);

    // timeout at 100 with only unrelated stores; hold for 20 cycles
    clear_sched();
    set_cfg(64'h4000, 32'd100);
    for (int k = 0; k < 100; k += 7) set_st(k, 64'h9000 + N'(k * 8), 64'h1, 1'b0);
    run_test(20, 1'b0);

    // final correct hit in the timeout cycle wins
    clear_sched();
    set_cfg(64'h1000, 32'd20);
    set_st(0, c_addr[0], c_exp[0], 1'b0);
    set_st(5, c_addr[1], c_exp[1], 1'b0);
    set_st(10, c_addr[2], c_exp[2], 1'b0);
    set_st(19, c_addr[3], c_exp[3], 1'b0);
    run_test(3, 1'b0);

    // wrong store in that same final cycle fails
    s_data[19] = c_exp[3] ^ 64'h80;
    run_test(3, 1'b0);

    // word store compares only the low 32 bits
    clear_sched();
    for (int i = 0; i < NS; i++) begin c_addr[i] = 64'h100; c_exp[i] = 64'h00C0FFEE; end
    c_max = '0;
    set_st(3, 64'h102, 64'hFFFF_FFFF_00C0_FFEE, 1'b1);
    run_test(2, 1'b0);

    // same data as a full store mismatches
    clear_sched();
    set_cfg(64'h200, '0);
    c_exp[0] = 64'h00C0FFEE;
    set_st(1, 64'h200, 64'hFFFF_FFFF_00C0_FFEE, 1'b0);
    run_test(2, 1'b0);

    // channels 1 and 3 share a word; a store matching neither reports channel 1
    clear_sched();
    set_cfg(64'h300, '0);
    c_addr[3] = c_addr[1] + 64'h5;
    c_exp[1] = 64'h1111; c_exp[3] = 64'h3333;
    set_st(4, c_addr[1], 64'h5555, 1'b0);
    run_test(2, 1'b0);

    // max_cycles = 1 times out after the first RUN cycle
    clear_sched();
    set_cfg(64'h500, 32'd1);
    run_test(2, 1'b0);

    for (int t = 0; t < 30; t++) begin
      gen_random();
      run_test($urandom_range(6, 1), 1'b1);
    end

    // abort a run with channel 0 hit, then a fresh run passes
    clear_sched();
    set_cfg(64'h700, '0);
    @(posedge clk); #1; drive_cfg(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    store_valid = 1'b1; store_addr = c_addr[0]; store_data = c_exp[0]; store_word = 1'b0;
    @(posedge clk); #1; store_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrun_hit_mask", 64'(hit_mask), 64'd1);
    check("midrun_cycle_count", 64'(cycle_count), 64'd2);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    for (int i = 0; i < NS; i++) set_st(2 * i + 1, c_addr[i], c_exp[i], 1'b0);
    run_test(3, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
